// File: rtl/pic_seq_pkg.sv
// Shared types and constants for the PIC16C5x Q-cycle sequencer and its decoder.
package pic_seq_pkg;

  localparam int unsigned EXC_W = 5;
  localparam int unsigned ALU_W = 5;

  typedef enum logic [EXC_W-1:0] {
    EXC_NOP, EXC_CLRF, EXC_CLRW, EXC_FSZ, EXC_MOVF, EXC_MOVWF, EXC_BXF, EXC_BTFSX,
    EXC_CALL, EXC_CLRWDT, EXC_GOTO, EXC_MOVLW, EXC_OPTION, EXC_RETLW, EXC_SLEEP,
    EXC_TRIS, EXC_ALUXLW, EXC_ELSE
  } exc_e;

  typedef enum logic [1:0] {PhQ1, PhQ2, PhQ3, PhQ4} phase_e;

  localparam logic [ALU_W-1:0] ALU_IDLE  = 5'd0;
  localparam logic [ALU_W-1:0] ALU_ADDWF = 5'd1;
  localparam logic [ALU_W-1:0] ALU_SUBWF = 5'd2;
  localparam logic [ALU_W-1:0] ALU_ANDWF = 5'd3;
  localparam logic [ALU_W-1:0] ALU_IORWF = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XORWF = 5'd5;
  localparam logic [ALU_W-1:0] ALU_COMF  = 5'd6;
  localparam logic [ALU_W-1:0] ALU_DECF  = 5'd7;
  localparam logic [ALU_W-1:0] ALU_INCF  = 5'd8;
  localparam logic [ALU_W-1:0] ALU_MOVF  = 5'd9;
  localparam logic [ALU_W-1:0] ALU_RRF   = 5'd10;
  localparam logic [ALU_W-1:0] ALU_RLF   = 5'd11;
  localparam logic [ALU_W-1:0] ALU_SWAPF = 5'd12;
  localparam logic [ALU_W-1:0] ALU_BCF   = 5'd13;
  localparam logic [ALU_W-1:0] ALU_BSF   = 5'd14;
  localparam logic [ALU_W-1:0] ALU_BTFS  = 5'd15;
  localparam logic [ALU_W-1:0] ALU_PASSK = 5'd16;
  localparam logic [ALU_W-1:0] ALU_IORLW = 5'd17;
  localparam logic [ALU_W-1:0] ALU_ANDLW = 5'd18;
  localparam logic [ALU_W-1:0] ALU_XORLW = 5'd19;
  localparam logic [ALU_W-1:0] ALU_CLR   = 5'd20;
  localparam logic [ALU_W-1:0] ALU_PASSW = 5'd21;

  localparam logic [1:0] STK_NOP  = 2'd0;
  localparam logic [1:0] STK_PUSH = 2'd1;
  localparam logic [1:0] STK_POP  = 2'd2;

  // Baseline 12-bit opcode patterns; '?' bits are operand fields matched by casez.
  localparam logic [11:0] OP_NOP    = 12'b0000_0000_0000;
  localparam logic [11:0] OP_OPTION = 12'b0000_0000_0010;
  localparam logic [11:0] OP_SLEEP  = 12'b0000_0000_0011;
  localparam logic [11:0] OP_CLRWDT = 12'b0000_0000_0100;
  localparam logic [11:0] OP_TRIS5  = 12'b0000_0000_0101;
  localparam logic [11:0] OP_TRIS6  = 12'b0000_0000_0110;
  localparam logic [11:0] OP_TRIS7  = 12'b0000_0000_0111;
  localparam logic [11:0] OP_MOVWF  = 12'b0000_001?_????;
  localparam logic [11:0] OP_CLRW   = 12'b0000_0100_0000;
  localparam logic [11:0] OP_CLRF   = 12'b0000_011?_????;
  localparam logic [11:0] OP_SUBWF  = 12'b0000_10??_????;
  localparam logic [11:0] OP_DECF   = 12'b0000_11??_????;
  localparam logic [11:0] OP_IORWF  = 12'b0001_00??_????;
  localparam logic [11:0] OP_ANDWF  = 12'b0001_01??_????;
  localparam logic [11:0] OP_XORWF  = 12'b0001_10??_????;
  localparam logic [11:0] OP_ADDWF  = 12'b0001_11??_????;
  localparam logic [11:0] OP_MOVF   = 12'b0010_00??_????;
  localparam logic [11:0] OP_COMF   = 12'b0010_01??_????;
  localparam logic [11:0] OP_INCF   = 12'b0010_10??_????;
  localparam logic [11:0] OP_DECFSZ = 12'b0010_11??_????;
  localparam logic [11:0] OP_RRF    = 12'b0011_00??_????;
  localparam logic [11:0] OP_RLF    = 12'b0011_01??_????;
  localparam logic [11:0] OP_SWAPF  = 12'b0011_10??_????;
  localparam logic [11:0] OP_INCFSZ = 12'b0011_11??_????;
  localparam logic [11:0] OP_BCF    = 12'b0100_????_????;
  localparam logic [11:0] OP_BSF    = 12'b0101_????_????;
  localparam logic [11:0] OP_BTFSX  = 12'b011?_????_????;
  localparam logic [11:0] OP_RETLW  = 12'b1000_????_????;
  localparam logic [11:0] OP_CALL   = 12'b1001_????_????;
  localparam logic [11:0] OP_GOTO   = 12'b101?_????_????;
  localparam logic [11:0] OP_MOVLW  = 12'b1100_????_????;
  localparam logic [11:0] OP_IORLW  = 12'b1101_????_????;
  localparam logic [11:0] OP_ANDLW  = 12'b1110_????_????;
  localparam logic [11:0] OP_XORLW  = 12'b1111_????_????;

  function automatic logic exc_is_branch(input exc_e c);
    return (c == EXC_CALL) || (c == EXC_GOTO) || (c == EXC_RETLW);
  endfunction

  function automatic logic exc_is_skip(input exc_e c);
    return (c == EXC_FSZ) || (c == EXC_BTFSX);
  endfunction

endpackage

// File: rtl/pic_inst_decode.sv
// Combinational instruction decode: ALU function, execute class and flush-relevant flags.
module pic_inst_decode
  import pic_seq_pkg::*;
#(
  parameter int unsigned INST_WIDTH     = 12,
  parameter int unsigned ALU_FUNC_WIDTH = 5
) (
  input  logic [INST_WIDTH-1:0]     inst_in,
  output logic [ALU_FUNC_WIDTH-1:0] alu_func,
  output exc_e                      ex_class,
  output logic                      is_branch,
  output logic                      is_skip
);

  logic [ALU_W-1:0] alu_code;

  if (INST_WIDTH == 12) begin : g_base
    always_comb begin
      alu_code = ALU_IDLE;
      ex_class = EXC_NOP;
      casez (inst_in)
        OP_NOP:    ;
        OP_OPTION: begin alu_code = ALU_PASSW; ex_class = EXC_OPTION; end
        OP_SLEEP:  ex_class = EXC_SLEEP;
        OP_CLRWDT: ex_class = EXC_CLRWDT;
        OP_TRIS5, OP_TRIS6, OP_TRIS7: begin alu_code = ALU_PASSW; ex_class = EXC_TRIS; end
        OP_MOVWF:  begin alu_code = ALU_PASSW; ex_class = EXC_MOVWF;  end
        OP_CLRW:   begin alu_code = ALU_CLR;   ex_class = EXC_CLRW;   end
        OP_CLRF:   begin alu_code = ALU_CLR;   ex_class = EXC_CLRF;   end
        OP_SUBWF:  begin alu_code = ALU_SUBWF; ex_class = EXC_ELSE;   end
        OP_DECF:   begin alu_code = ALU_DECF;  ex_class = EXC_ELSE;   end
        OP_IORWF:  begin alu_code = ALU_IORWF; ex_class = EXC_ELSE;   end
        OP_ANDWF:  begin alu_code = ALU_ANDWF; ex_class = EXC_ELSE;   end
        OP_XORWF:  begin alu_code = ALU_XORWF; ex_class = EXC_ELSE;   end
        OP_ADDWF:  begin alu_code = ALU_ADDWF; ex_class = EXC_ELSE;   end
        OP_MOVF:   begin alu_code = ALU_MOVF;  ex_class = EXC_MOVF;   end
        OP_COMF:   begin alu_code = ALU_COMF;  ex_class = EXC_ELSE;   end
        OP_INCF:   begin alu_code = ALU_INCF;  ex_class = EXC_ELSE;   end
        OP_DECFSZ: begin alu_code = ALU_DECF;  ex_class = EXC_FSZ;    end
        OP_RRF:    begin alu_code = ALU_RRF;   ex_class = EXC_ELSE;   end
        OP_RLF:    begin alu_code = ALU_RLF;   ex_class = EXC_ELSE;   end
        OP_SWAPF:  begin alu_code = ALU_SWAPF; ex_class = EXC_ELSE;   end
        OP_INCFSZ: begin alu_code = ALU_INCF;  ex_class = EXC_FSZ;    end
        OP_BCF:    begin alu_code = ALU_BCF;   ex_class = EXC_BXF;    end
        OP_BSF:    begin alu_code = ALU_BSF;   ex_class = EXC_BXF;    end
        OP_BTFSX:  begin alu_code = ALU_BTFS;  ex_class = EXC_BTFSX;  end
        OP_RETLW:  begin alu_code = ALU_PASSK; ex_class = EXC_RETLW;  end
        OP_CALL:   ex_class = EXC_CALL;
        OP_GOTO:   ex_class = EXC_GOTO;
        OP_MOVLW:  begin alu_code = ALU_PASSK; ex_class = EXC_MOVLW;  end
        OP_IORLW:  begin alu_code = ALU_IORLW; ex_class = EXC_ALUXLW; end
        OP_ANDLW:  begin alu_code = ALU_ANDLW; ex_class = EXC_ALUXLW; end
        OP_XORLW:  begin alu_code = ALU_XORLW; ex_class = EXC_ALUXLW; end
        default:   ;
      endcase
    end
  end else begin : g_reserved
    // 14-bit opcode map is reserved: everything decodes as a NOP.
    assign alu_code = ALU_IDLE;
    assign ex_class = EXC_NOP;
  end

  assign alu_func  = ALU_FUNC_WIDTH'(alu_code);
  assign is_branch = exc_is_branch(ex_class);
  assign is_skip   = exc_is_skip(ex_class);

endmodule

// File: rtl/pic_exec_sequencer.sv
// Q1..Q4 instruction-cycle sequencer: phase, fetch strobe, flush/sleep control and stack pointer.
module pic_exec_sequencer
  import pic_seq_pkg::*;
#(
  parameter int unsigned INST_WIDTH     = 12,
  parameter int unsigned ALU_FUNC_WIDTH = 5,
  parameter int unsigned STACK_DEPTH    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [INST_WIDTH-1:0]          inst_in,
  input  logic                           skip_cond,
  input  logic                           wake,
  input  logic                           stall,
  output logic [1:0]                     q_phase,
  output logic                           fetch_en,
  output exc_e                           ex_class,
  output logic [ALU_FUNC_WIDTH-1:0]      alu_func,
  output logic [1:0]                     stk_cmd,
  output logic [$clog2(STACK_DEPTH)-1:0] stk_ptr,
  output logic                           stk_ovf,
  output logic                           flush,
  output logic                           sleeping
);

  localparam int unsigned PtrW = $clog2(STACK_DEPTH);
  localparam logic [PtrW-1:0] PtrFull = PtrW'(STACK_DEPTH - 1);

  phase_e                    phase_q, phase_d;
  logic                      flush_q, flush_d;
  logic                      sleeping_q, sleeping_d;
  logic [ALU_FUNC_WIDTH-1:0] alu_func_q, alu_func_d;
  exc_e                      ex_class_q, ex_class_d;
  logic [PtrW-1:0]           stk_ptr_q, stk_ptr_d;
  logic                      stk_ovf_q, stk_ovf_d;
  logic                      advance;

  logic [ALU_FUNC_WIDTH-1:0] dec_alu;
  exc_e                      dec_class;
  logic                      dec_branch, dec_skip;

  pic_inst_decode #(
    .INST_WIDTH     (INST_WIDTH),
    .ALU_FUNC_WIDTH (ALU_FUNC_WIDTH)
  ) u_decode (
    .inst_in   (inst_in),
    .alu_func  (dec_alu),
    .ex_class  (dec_class),
    .is_branch (dec_branch),
    .is_skip   (dec_skip)
  );

  assign advance = ~stall & ~sleeping_q;

  // Stack command is a pure function of the latched Q4 class so it holds across a stall.
  always_comb begin
    stk_cmd = STK_NOP;
    if ((phase_q == PhQ4) && !flush_q) begin
      if (ex_class_q == EXC_CALL) begin
        stk_cmd = STK_PUSH;
      end else if (ex_class_q == EXC_RETLW) begin
        stk_cmd = STK_POP;
      end
    end
  end

  always_comb begin
    phase_d    = phase_q;
    flush_d    = flush_q;
    sleeping_d = sleeping_q;
    alu_func_d = alu_func_q;
    ex_class_d = ex_class_q;
    stk_ptr_d  = stk_ptr_q;
    stk_ovf_d  = stk_ovf_q;

    if (sleeping_q && wake) begin
      sleeping_d = 1'b0;
    end

    if (advance) begin
      unique case (phase_q)
        PhQ1: phase_d = PhQ2;
        PhQ2: begin
          phase_d    = PhQ3;
          alu_func_d = flush_q ? ALU_FUNC_WIDTH'(ALU_IDLE) : dec_alu;
        end
        PhQ3: begin
          phase_d    = PhQ4;
          ex_class_d = flush_q ? EXC_NOP : dec_class;
        end
        PhQ4: begin
          phase_d = PhQ1;
          flush_d = ~flush_q & (dec_branch | (dec_skip & skip_cond));
          if (stk_cmd == STK_PUSH) begin
            stk_ptr_d = stk_ptr_q + PtrW'(1);
            if (stk_ptr_q == PtrFull) stk_ovf_d = 1'b1;
          end else if (stk_cmd == STK_POP) begin
            stk_ptr_d = stk_ptr_q - PtrW'(1);
            if (stk_ptr_q == '0) stk_ovf_d = 1'b1;
          end
          if (!flush_q && (ex_class_q == EXC_SLEEP)) sleeping_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= PhQ3;
      flush_q    <= 1'b1;
      sleeping_q <= 1'b0;
      alu_func_q <= ALU_FUNC_WIDTH'(ALU_IDLE);
      ex_class_q <= EXC_NOP;
      stk_ptr_q  <= '0;
      stk_ovf_q  <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      flush_q    <= flush_d;
      sleeping_q <= sleeping_d;
      alu_func_q <= alu_func_d;
      ex_class_q <= ex_class_d;
      stk_ptr_q  <= stk_ptr_d;
      stk_ovf_q  <= stk_ovf_d;
    end
  end

  assign q_phase  = phase_q;
  assign fetch_en = (phase_q == PhQ3) & ~stall & ~sleeping_q;
  assign ex_class = ex_class_q;
  assign alu_func = alu_func_q;
  assign stk_ptr  = stk_ptr_q;
  assign stk_ovf  = stk_ovf_q;
  assign flush    = flush_q;
  assign sleeping = sleeping_q;

endmodule

// File: tb/tb_pic_exec_sequencer.sv
// Directed bench for pic_exec_sequencer with an instruction-cycle reference model.
module tb_pic_exec_sequencer;
  import pic_seq_pkg::*;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [11:0] inst_in;
  logic        skip_cond;
  logic        wake;
  logic        stall;
  logic [1:0]  q_phase;
  logic        fetch_en;
  exc_e        ex_class;
  logic [4:0]  alu_func;
  logic [1:0]  stk_cmd;
  logic [$clog2(DEPTH)-1:0] stk_ptr;
  logic        stk_ovf;
  logic        flush;
  logic        sleeping;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  pic_exec_sequencer #(
    .INST_WIDTH     (12),
    .ALU_FUNC_WIDTH (5),
    .STACK_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_in   (inst_in),
    .skip_cond (skip_cond),
    .wake      (wake),
    .stall     (stall),
    .q_phase   (q_phase),
    .fetch_en  (fetch_en),
    .ex_class  (ex_class),
    .alu_func  (alu_func),
    .stk_cmd   (stk_cmd),
    .stk_ptr   (stk_ptr),
    .stk_ovf   (stk_ovf),
    .flush     (flush),
    .sleeping  (sleeping)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the PIC16C5x opcode map, organised by opcode ranges.
  function automatic exc_e ref_exc(input int i);
    int hi6;
    hi6 = i >> 6;
    if (i >= 'hD00) return EXC_ALUXLW;
    if (i >= 'hC00) return EXC_MOVLW;
    if (i >= 'hA00) return EXC_GOTO;
    if (i >= 'h900) return EXC_CALL;
    if (i >= 'h800) return EXC_RETLW;
    if (i >= 'h600) return EXC_BTFSX;
    if (i >= 'h400) return EXC_BXF;
    if (hi6 == 8) return EXC_MOVF;
    if (hi6 == 11 || hi6 == 15) return EXC_FSZ;
    if (i >= 'h080) return EXC_ELSE;
    if (i >= 'h060) return EXC_CLRF;
    if (i == 'h040) return EXC_CLRW;
    if (i >= 'h020 && i < 'h040) return EXC_MOVWF;
    case (i)
      2: return EXC_OPTION;
      3: return EXC_SLEEP;
      4: return EXC_CLRWDT;
      5, 6, 7: return EXC_TRIS;
      default: return EXC_NOP;
    endcase
  endfunction

  function automatic logic [4:0] ref_alu(input int i);
    case (i >> 8)
      'hF: return ALU_XORLW;
      'hE: return ALU_ANDLW;
      'hD: return ALU_IORLW;
      'hC, 8: return ALU_PASSK;
      'hA, 'hB, 9: return ALU_IDLE;
      6, 7: return ALU_BTFS;
      5: return ALU_BSF;
      4: return ALU_BCF;
      default: ;
    endcase
    case (i >> 6)
      2: return ALU_SUBWF;
      3, 11: return ALU_DECF;
      4: return ALU_IORWF;
      5: return ALU_ANDWF;
      6: return ALU_XORWF;
      7: return ALU_ADDWF;
      8: return ALU_MOVF;
      9: return ALU_COMF;
      10, 15: return ALU_INCF;
      12: return ALU_RRF;
      13: return ALU_RLF;
      14: return ALU_SWAPF;
      default: ;
    endcase
    if (i == 'h040 || (i >= 'h060 && i < 'h080)) return ALU_CLR;
    if ((i >= 'h020 && i < 'h040) || i == 2 || (i >= 5 && i <= 7)) return ALU_PASSW;
    return ALU_IDLE;
  endfunction

  // Model state: phase as 0..3, stack pointer as a plain integer modulo DEPTH.
  int   m_phase, m_sp;
  bit   m_flush, m_sleep, m_ovf;
  logic [4:0] m_alu;
  exc_e m_exc;

  always @(posedge clk) begin
    int   np, nsp;
    bit   nfl, nsl, nov;
    logic [4:0] nalu;
    exc_e nexc;
    np = m_phase; nsp = m_sp; nfl = m_flush; nsl = m_sleep; nov = m_ovf;
    nalu = m_alu; nexc = m_exc;
    if (rst) begin
      np = 2; nfl = 1; nsl = 0; nov = 0; nsp = 0; nalu = ALU_IDLE; nexc = EXC_NOP;
    end else begin
      if (m_sleep && wake) nsl = 0;
      if (!stall && !m_sleep) begin
        np = (m_phase + 1) % 4;
        if (m_phase == 1) nalu = m_flush ? ALU_IDLE : ref_alu(int'(inst_in));
        if (m_phase == 2) nexc = m_flush ? EXC_NOP : ref_exc(int'(inst_in));
        if (m_phase == 3) begin
          nfl = 0;
          if (!m_flush) begin
            if (m_exc == EXC_CALL) begin
              if (m_sp == DEPTH - 1) nov = 1;
              nsp = (m_sp + 1) % DEPTH;
            end
            if (m_exc == EXC_RETLW) begin
              if (m_sp == 0) nov = 1;
              nsp = (m_sp + DEPTH - 1) % DEPTH;
            end
            if (m_exc == EXC_SLEEP) nsl = 1;
            nfl = (m_exc inside {EXC_CALL, EXC_GOTO, EXC_RETLW}) ||
                  ((m_exc inside {EXC_FSZ, EXC_BTFSX}) && skip_cond);
          end
        end
      end
    end
    m_phase <= np; m_sp <= nsp; m_flush <= nfl; m_sleep <= nsl; m_ovf <= nov;
    m_alu <= nalu; m_exc <= nexc;
  end

  always @(negedge clk) begin
    int exp_cmd;
    if (chk_en) begin
      exp_cmd = 0;
      if (m_phase == 3 && !m_flush && m_exc == EXC_CALL) exp_cmd = STK_PUSH;
      if (m_phase == 3 && !m_flush && m_exc == EXC_RETLW) exp_cmd = STK_POP;
      chk("q_phase", q_phase, m_phase);
      chk("fetch_en", fetch_en, (m_phase == 2 && !stall && !m_sleep));
      chk("ex_class", ex_class, m_exc);
      chk("alu_func", alu_func, m_alu);
      chk("stk_cmd", stk_cmd, exp_cmd);
      chk("stk_ptr", stk_ptr, m_sp);
      chk("stk_ovf", stk_ovf, m_ovf);
      chk("flush", flush, m_flush);
      chk("sleeping", sleeping, m_sleep);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in Q1: present an instruction and run to its Q4.
  task automatic start(input logic [11:0] i, input logic s);
    inst_in = i;
    skip_cond = s;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1; inst_in = 12'h000; skip_cond = 0; wake = 0; stall = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    chk("rst_phase_q3", q_phase, 2);
    chk("rst_flush", flush, 1);
    chk("rst_fetch_q3", fetch_en, 1);
    chk("rst_stk_ptr", stk_ptr, 0);
    tick();
    chk("first_q4_phase", q_phase, 3);
    chk("first_q4_fetch", fetch_en, 0);
    chk("first_exc_nop", ex_class, EXC_NOP);
    chk("first_flush", flush, 1);
    tick();
    chk("first_q1_phase", q_phase, 0);
    chk("flush_cleared", flush, 0);

    start(12'h1C7, 0);
    chk("addwf_alu", alu_func, ALU_ADDWF);
    chk("addwf_exc", ex_class, EXC_ELSE);
    chk("addwf_cmd", stk_cmd, STK_NOP);
    tick();
    chk("addwf_noflush", flush, 0);

    for (int k = 0; k < 3; k++) begin
      start(12'h905, 0);
      chk("call_push", stk_cmd, STK_PUSH);
      tick();
      chk("call_ptr", stk_ptr, (k == 1) ? 0 : 1);
      chk("call_ovf", stk_ovf, (k >= 1) ? 1 : 0);
      chk("call_flush", flush, 1);
      start(12'h0A5, 0);
      chk("call_shadow_exc", ex_class, EXC_NOP);
      chk("call_shadow_cmd", stk_cmd, STK_NOP);
      tick();
    end

    start(12'h2C7, 1);
    chk("fsz_exc", ex_class, EXC_FSZ);
    tick();
    chk("fsz_skip_flush", flush, 1);
    start(12'h905, 0);
    chk("skipped_call_exc", ex_class, EXC_NOP);
    chk("skipped_call_cmd", stk_cmd, STK_NOP);
    tick();
    chk("skipped_call_ptr", stk_ptr, 1);
    start(12'h2C7, 0);
    tick();
    chk("fsz_noskip_flush", flush, 0);

    start(12'hA05, 0);
    tick();
    chk("goto_flush", flush, 1);
    start(12'h000, 0);
    tick();

    start(12'h003, 0);
    chk("sleep_exc", ex_class, EXC_SLEEP);
    tick();
    chk("sleep_enter", sleeping, 1);
    for (int k = 0; k < 20; k++) begin
      stall = k[0];
      tick();
      chk("sleep_hold_q1", q_phase, 0);
      chk("sleep_hold_flag", sleeping, 1);
    end
    stall = 0; wake = 1; inst_in = 12'h000;
    tick();
    chk("wake_clear", sleeping, 0);
    chk("wake_still_q1", q_phase, 0);
    wake = 0;
    tick();
    chk("wake_q2", q_phase, 1);
    tick(); tick(); tick();

    start(12'h003, 0);
    tick();
    wake = 1; stall = 1; inst_in = 12'h000;
    tick();
    chk("wake_stall_clear", sleeping, 0);
    chk("wake_stall_hold", q_phase, 0);
    wake = 0;
    tick();
    chk("stall_hold_q1", q_phase, 0);
    stall = 0;
    tick();
    tick(); tick(); tick();

    start(12'h812, 0);
    chk("retlw_pop", stk_cmd, STK_POP);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("retlw_stall_cmd", stk_cmd, STK_POP);
      chk("retlw_stall_ptr", stk_ptr, 1);
    end
    stall = 0;
    tick();
    chk("retlw_ptr_once", stk_ptr, 0);
    chk("retlw_flush", flush, 1);
    start(12'h000, 0);
    tick();

    start(12'h003, 0);
    tick(); tick();
    chk("sleep2_enter", sleeping, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_sleep_phase", q_phase, 2);
    chk("rst_sleep_flush", flush, 1);
    chk("rst_sleep_flag", sleeping, 0);
    chk("rst_sleep_ovf", stk_ovf, 0);
    tick(); tick();
    start(12'h1C7, 0);
    tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
